req_merge: RTL and testbench

Clocked, parametrised successor to the asynchronous request-OR collector. It watches `REQ_NUM` request lines for rising edges and captures them per channel without loss. When the configured condition is met (any enabled channel, or all enabled channels), it emits a `fin` pulse of programmable width and reports which channels caused it. It sits between the flow-control stages and the synchronous controller, replacing the self-clearing latch scheme with a deterministic state machine.

---
 rtl/req_merge_pkg.sv | 14 +
 rtl/req_edge_det.sv | 47 ++++
 rtl/req_merge.sv | 105 ++++++++++
 tb/tb_req_merge.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/req_merge_pkg.sv
// Shared types and constants for the req_merge request collector.
package req_merge_pkg;

  typedef enum logic [1:0] {
    IDLE,
    FIRE,
    GAP
  } req_merge_state_t;

  localparam int MODE_ANY     = 0;
  localparam int MODE_ALL_REQ = 1;
  localparam int FIN_LEN_W    = 8;

endpackage

// File: rtl/req_edge_det.sv
// One request channel: optional two-flop synchroniser (REQ_MERGE_SYNC_EN),
// then the s1/s2 sampling stages and a rising-edge output.
module req_edge_det (
  input  logic clk,
  input  logic rstn,
  input  logic req,
  output logic rise
);

  logic samp;
  logic s1;
  logic s2;

`ifdef REQ_MERGE_SYNC_EN
  logic m1;
  logic m2;

  // Metastability guard for requests arriving from an unrelated clock domain.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      m1 <= 1'b0;
      m2 <= 1'b0;
    end else begin
      m1 <= req;
      m2 <= m1;
    end
  end

  assign samp = m2;
`else
  assign samp = req;
`endif

  // s1/s2 reset low, so a line already high at reset release counts as an edge.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= samp;
      s2 <= s1;
    end
  end

  assign rise = s1 & ~s2;

endmodule

// File: rtl/req_merge.sv
// Clocked request merger: captures request edges per channel and emits a
// fixed-width fin pulse when the any/all condition holds. Option: REQ_MERGE_SYNC_EN.
module req_merge
  import req_merge_pkg::*;
#(
  parameter int REQ_NUM  = 4,
  parameter int MODE_ALL = 0,
  parameter int FIN_LEN  = 1,
  parameter int CNT_W    = 8
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic [REQ_NUM-1:0] reqs,
  input  logic [REQ_NUM-1:0] mask,
  output logic               fin,
  output logic [REQ_NUM-1:0] fin_src,
  output logic               busy,
  output logic [CNT_W-1:0]   fin_cnt
);

  localparam logic [FIN_LEN_W-1:0] WIDTH_LOAD = FIN_LEN_W'(FIN_LEN - 1);

  req_merge_state_t     state;
  req_merge_state_t     state_nxt;
  logic [REQ_NUM-1:0]   e;
  logic [REQ_NUM-1:0]   pend;
  logic [REQ_NUM-1:0]   pend_nxt;
  logic [FIN_LEN_W-1:0] wcnt;
  logic [FIN_LEN_W-1:0] wcnt_nxt;
  logic                 trig;
  logic                 capture;

  for (genvar i = 0; i < REQ_NUM; i++) begin : g_det
    req_edge_det u_det (
      .clk  (clk),
      .rstn (rstn),
      .req  (reqs[i]),
      .rise (e[i])
    );
  end

  // A fully masked channel set can never fire in either mode.
  always_comb begin
    if (MODE_ALL == MODE_ANY) begin
      trig = |(pend & mask);
    end else begin
      trig = (&(pend | ~mask)) && (|mask);
    end
  end

  always_comb begin
    state_nxt = state;
    wcnt_nxt  = wcnt;
    capture   = 1'b0;
    case (state)
      IDLE: begin
        if (trig) begin
          state_nxt = FIRE;
          wcnt_nxt  = WIDTH_LOAD;
          capture   = 1'b1;
        end
      end
      FIRE: begin
        if (wcnt == '0) begin
          state_nxt = GAP;
        end else begin
          wcnt_nxt = wcnt - 1'b1;
        end
      end
      GAP:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Edges seen on the capture cycle seed the new pending set; mask-clear wins.
  always_comb begin
    if (capture) begin
      pend_nxt = e & mask;
    end else begin
      pend_nxt = (pend | (e & mask)) & mask;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state   <= IDLE;
      wcnt    <= '0;
      pend    <= '0;
      fin_src <= '0;
      fin_cnt <= '0;
    end else begin
      state <= state_nxt;
      wcnt  <= wcnt_nxt;
      pend  <= pend_nxt;
      if (capture) begin
        fin_src <= pend;
        fin_cnt <= fin_cnt + 1'b1;
      end
    end
  end

  assign fin  = (state == FIRE);
  assign busy = (state != IDLE);

endmodule

// File: tb/tb_req_merge.sv
// Randomised scoreboard bench for req_merge: an ANY-mode and an ALL-mode
// instance share the request lines and are checked against a timing model.
module tb_req_merge;

`ifdef REQ_MERGE_SYNC_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 0;
`endif

  typedef struct {
    int         id;
    int         t;
    logic [3:0] src;
    int         cnt;
  } exp_t;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic [3:0] reqs = 4'b0000;
  logic [3:0] mask_a = 4'b1111;
  logic [3:0] mask_b = 4'b0000;

  logic       fin_a, busy_a, fin_b, busy_b;
  logic [3:0] fin_src_a, fin_src_b;
  logic [1:0] fin_cnt_a;
  logic [7:0] fin_cnt_b;

  int n_checks = 0;
  int n_fail   = 0;
  int edge_cnt = 0;

  exp_t       expq[$];
  logic [3:0] hist[4];
  logic [3:0] pend_m[2];
  int         cnt_m[2];
  int         last_fire[2];
  int         obs_fires[2];

  logic       prev_f[2];
  int         hi_cnt[2];
  logic       mf, mb;
  logic [3:0] msrc;
  int         mcnt;
  int         midx[$];
  int         got;
  int         fires_before;

  req_merge #(.REQ_NUM(4), .MODE_ALL(0), .FIN_LEN(4), .CNT_W(2)) dut_a (
    .clk(clk), .rstn(rstn), .reqs(reqs), .mask(mask_a),
    .fin(fin_a), .fin_src(fin_src_a), .busy(busy_a), .fin_cnt(fin_cnt_a)
  );

  req_merge #(.REQ_NUM(4), .MODE_ALL(1), .FIN_LEN(1), .CNT_W(8)) dut_b (
    .clk(clk), .rstn(rstn), .reqs(reqs), .mask(mask_b),
    .fin(fin_b), .fin_src(fin_src_b), .busy(busy_b), .fin_cnt(fin_cnt_b)
  );

  always #5 clk = ~clk;

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  function automatic int flen(input int d);
    return (d == 0) ? 4 : 1;
  endfunction

  function automatic int cmod(input int d);
    return (d == 0) ? 4 : 256;
  endfunction

  task automatic checkOutput(input string nm, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic modelReset();
    for (int k = 0; k < 4; k++) hist[k] = 4'b0000;
    for (int d = 0; d < 2; d++) begin
      pend_m[d]    = 4'b0000;
      cnt_m[d]     = 0;
      last_fire[d] = -1000;
    end
    expq.delete();
  endtask

  // Predict what the coming clock edge does, from the spec's rules:
  // edges appear LAT+2 edges after sampling, fires are spaced FIN_LEN+2 apart.
  task automatic modelStep();
    logic [3:0] ev, m, p;
    logic       trig;
    int         t;
    t  = edge_cnt + 1;
    ev = hist[LAT] & ~hist[LAT+1];
    for (int d = 0; d < 2; d++) begin
      m = (d == 0) ? mask_a : mask_b;
      p = pend_m[d];
      if (d == 0) trig = |(p & m);
      else        trig = (&(p | ~m)) && (m != 4'b0000);
      if (((t - last_fire[d]) >= flen(d) + 2) && trig) begin
        cnt_m[d] = (cnt_m[d] + 1) % cmod(d);
        expq.push_back('{d, t, p, cnt_m[d]});
        last_fire[d] = t;
        pend_m[d] = ev & m;
      end else begin
        pend_m[d] = (p | (ev & m)) & m;
      end
    end
    for (int k = 3; k > 0; k--) hist[k] = hist[k-1];
    hist[0] = reqs;
  endtask

  task automatic applyStimulus(input logic [3:0] r, input logic [3:0] ma, input logic [3:0] mb);
    @(negedge clk);
    reqs   = r;
    mask_a = ma;
    mask_b = mb;
    if (rstn) modelStep();
  endtask

  // Monitor: compares every fire against the scoreboard and checks pulse shape.
  always @(negedge clk) begin
    if (!rstn) begin
      for (int d = 0; d < 2; d++) begin
        prev_f[d] = 1'b0;
        hi_cnt[d] = 0;
      end
    end else begin
      for (int d = 0; d < 2; d++) begin
        mf   = (d == 0) ? fin_a : fin_b;
        mb   = (d == 0) ? busy_a : busy_b;
        msrc = (d == 0) ? fin_src_a : fin_src_b;
        mcnt = (d == 0) ? int'(fin_cnt_a) : int'(fin_cnt_b);
        checkOutput($sformatf("dut%0d busy", d), int'(mb), int'(mf | prev_f[d]));
        if (mf && !prev_f[d]) begin
          obs_fires[d]++;
          midx = expq.find_first_index(x) with (x.id == d);
          checkOutput($sformatf("dut%0d fire expected", d), midx.size(), 1);
          if (midx.size() > 0) begin
            checkOutput($sformatf("dut%0d fire edge", d), edge_cnt, expq[midx[0]].t);
            checkOutput($sformatf("dut%0d fin_src", d), int'(msrc), int'(expq[midx[0]].src));
            checkOutput($sformatf("dut%0d fin_cnt", d), mcnt, expq[midx[0]].cnt);
            expq.delete(midx[0]);
          end
        end
        if (mf) hi_cnt[d]++;
        if (!mf && prev_f[d]) begin
          checkOutput($sformatf("dut%0d fin width", d), hi_cnt[d], flen(d));
          hi_cnt[d] = 0;
        end
        midx = expq.find_index(x) with (x.id == d && x.t < edge_cnt);
        checkOutput($sformatf("dut%0d overdue fires", d), midx.size(), 0);
        if (midx.size() > 0) expq.delete(midx[0]);
        prev_f[d] = mf;
      end
    end
  end

  initial begin
    obs_fires[0] = 0;
    obs_fires[1] = 0;
    modelReset();
    #12;
    checkOutput("reset fin_a", int'(fin_a), 0);
    checkOutput("reset busy_a", int'(busy_a), 0);
    checkOutput("reset fin_src_a", int'(fin_src_a), 0);
    checkOutput("reset fin_cnt_a", int'(fin_cnt_a), 0);
    checkOutput("reset fin_b", int'(fin_b), 0);
    checkOutput("reset fin_cnt_b", int'(fin_cnt_b), 0);
    @(negedge clk);
    rstn = 1'b1;
    modelStep();

    $display("[TB] ANY single request on channel 2");
    repeat (3)  applyStimulus(4'b0000, 4'b1111, 4'b0000);
    repeat (10) applyStimulus(4'b0100, 4'b1111, 4'b0000);
    repeat (6)  applyStimulus(4'b0000, 4'b1111, 4'b1011);

    $display("[TB] ALL join on mask 1011 with channel 2 toggling");
    repeat (5)  applyStimulus(4'b0001, 4'b1111, 4'b1011);
    repeat (5)  applyStimulus(4'b1101, 4'b1111, 4'b1011);
    repeat (5)  applyStimulus(4'b1011, 4'b1111, 4'b1011);
    repeat (10) applyStimulus(4'b1111, 4'b1111, 4'b1011);
    repeat (8)  applyStimulus(4'b0000, 4'b1111, 4'b1011);

    $display("[TB] back-to-back requests during FIRE");
    repeat (4)  applyStimulus(4'b0010, 4'b1111, 4'b0000);
    repeat (12) applyStimulus(4'b0011, 4'b1111, 4'b0000);
    repeat (4)  applyStimulus(4'b0000, 4'b1111, 4'b0000);

    $display("[TB] edge on the capture cycle");
    repeat (2)  applyStimulus(4'b0001, 4'b1111, 4'b0000);
    repeat (14) applyStimulus(4'b1001, 4'b1111, 4'b0000);
    repeat (4)  applyStimulus(4'b0000, 4'b1111, 4'b1011);

    $display("[TB] mask clear while pending in ALL mode");
    fires_before = obs_fires[1];
    repeat (4)  applyStimulus(4'b0010, 4'b1111, 4'b1011);
    repeat (8)  applyStimulus(4'b0010, 4'b1111, 4'b1001);
    repeat (8)  applyStimulus(4'b0000, 4'b1111, 4'b1011);
    checkOutput("masked join fires", obs_fires[1], fires_before);

    $display("[TB] reset during FIRE");
    got = 0;
    for (int i = 0; i < 20 && got == 0; i++) begin
      applyStimulus(4'b0001, 4'b1111, 4'b0000);
      if (fin_a) got = 1;
    end
    checkOutput("fin_a before reset", got, 1);
    @(posedge clk);
    #2;
    rstn = 1'b0;
    modelReset();
    #1;
    checkOutput("async reset fin_a", int'(fin_a), 0);
    checkOutput("async reset busy_a", int'(busy_a), 0);
    checkOutput("async reset fin_cnt_a", int'(fin_cnt_a), 0);
    checkOutput("async reset fin_src_a", int'(fin_src_a), 0);
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    modelStep();
    repeat (12) applyStimulus(4'b0001, 4'b1111, 4'b0000);
    repeat (4)  applyStimulus(4'b0000, 4'b1111, 4'b0000);

    $display("[TB] randomised traffic");
    for (int i = 0; i < 800; i++) begin
      if (i % 64 == 0) applyStimulus(4'($urandom), 4'($urandom), 4'($urandom));
      else             applyStimulus(4'($urandom), mask_a, mask_b);
    end
    repeat (12) applyStimulus(4'b0000, 4'b0000, 4'b0000);
    checkOutput("scoreboard drained", expq.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
